// File: rtl/vstreamin_scheduler.sv
// vstreamin_scheduler: serves latched column stream-in requests in ascending order, vec_len beats each.
// Ports: clk, rst_n (async, active-low); is_vstreamin/base_addr/vec_len request captured in IDLE;
// abort cancels a job; s_tdata/s_tvalid/s_tready stream input; wr_en/wr_addr/wr_data RF write
// port (1-cycle latency); consumer one-hot served column; busy job flag; done completion pulse.
// Optional VSTREAMIN_TLAST_EN adds s_tlast input and sticky len_err output.
module vstreamin_scheduler #(
  parameter int NUM_COL = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_COL-1:0] is_vstreamin,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0] vec_len,
  input  logic abort,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic s_tvalid,
`ifdef VSTREAMIN_TLAST_EN
  input  logic s_tlast,
  output logic len_err,
`endif
  output logic s_tready,
  output logic [NUM_COL-1:0] wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NUM_COL-1:0] consumer,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {IDLE, SELECT, STREAM, FINISH} state_t;
  state_t state;
  logic [NUM_COL-1:0] mask, low, rest;
  logic [LEN_W-1:0] len, cnt;
  logic [ADDR_W-1:0] base, addr;
  logic beat, last;
  assign beat = s_tvalid & s_tready;
  assign last = cnt == len - LEN_W'(1);
  // isolate the lowest pending column
  assign low = mask & (~mask + NUM_COL'(1));
  assign rest = mask & ~consumer;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      len <= '0;
      cnt <= '0;
      base <= '0;
      addr <= '0;
      s_tready <= 1'b0;
      wr_en <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      consumer <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef VSTREAMIN_TLAST_EN
      len_err <= 1'b0;
`endif
    end else begin
      wr_en <= '0;
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        s_tready <= 1'b0;
        busy <= 1'b0;
        consumer <= '0;
      end else begin
        case (state)
          IDLE: if (|is_vstreamin) begin
            mask <= is_vstreamin;
            len <= vec_len;
            base <= base_addr;
            busy <= 1'b1;
            state <= SELECT;
`ifdef VSTREAMIN_TLAST_EN
            len_err <= 1'b0;
`endif
          end
          SELECT: begin
            consumer <= low;
            addr <= base;
            cnt <= '0;
            // zero length serves every latched column without taking beats
            if (mask == '0 || len == '0) begin
              mask <= '0;
              done <= 1'b1;
              state <= FINISH;
            end else begin
              s_tready <= 1'b1;
              state <= STREAM;
            end
          end
          STREAM: if (beat) begin
            wr_en <= consumer;
            wr_addr <= addr;
            wr_data <= s_tdata;
            addr <= addr + ADDR_W'(1);
            cnt <= cnt + LEN_W'(1);
`ifdef VSTREAMIN_TLAST_EN
            if (s_tlast != last) len_err <= 1'b1;
`endif
            if (last) begin
              mask <= rest;
              s_tready <= 1'b0;
              done <= ~|rest;
              state <= |rest ? SELECT : FINISH;
            end
          end
          FINISH: begin
            busy <= 1'b0;
            consumer <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/vstreamin_scheduler.md
Name: vstreamin_scheduler

Overview:
- Sequences an incoming vector stream into the per-column register files of the CGRA array, one column at a time.
- Latches which columns request a stream-in, then serves them in ascending column order. Each served column receives exactly vec_len beats, written at base_addr, base_addr+1, and so on.
- Sits between the network-side stream input and the column RF write ports. It is the input-side counterpart of the stream-out column sequencer.

Parameters:
- NUM_COL, 8, number of CGRA columns.
- ADDR_W, 5, RF address width.
- DATA_W, 32, stream and RF data width.
- LEN_W, 8, vector length field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- is_vstreamin  in  NUM_COL  per-column stream-in request, level.
- base_addr  in  ADDR_W  first RF address; sampled at start.
- vec_len  in  LEN_W  beats per column; sampled at start.
- abort  in  1  synchronous cancel of the current job.
- s_tdata  in  DATA_W  stream data.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- wr_en  out  NUM_COL  one-hot RF write enable.
- wr_addr  out  ADDR_W  RF write address.
- wr_data  out  DATA_W  RF write data.
- consumer  out  NUM_COL  one-hot column currently being served; 0 when idle.
- busy  out  1  job in progress (global stream-in flag).
- done  out  1  one-cycle pulse when a job completes.

Behaviour:
- Reset (async, rst_n=0) forces all outputs to 0:
  - state=IDLE, s_tready=0, wr_en=0, wr_addr=0, wr_data=0, consumer=0, busy=0, done=0.
  - Internal mask, counters and address are also cleared.
- Reset mid-job discards the job; no done pulse is generated.

FSM states: IDLE, SELECT, STREAM, FINISH.
- IDLE:
  - When |is_vstreamin, latch mask=is_vstreamin, len=vec_len and base=base_addr, then go to SELECT.
  - busy rises in the same cycle as the transition.
- SELECT (1 cycle):
  - consumer = lowest set bit of mask; addr=base; beat count=0.
  - If mask==0, or len==0, go to FINISH. When len==0, no beats are taken and every latched column is treated as served.
  - Otherwise go to STREAM.
- STREAM:
  - s_tready=1.
  - A beat occurs when s_tvalid&s_tready.
  - On each beat, in the next cycle: wr_en=consumer, wr_addr=addr, wr_data=s_tdata. Fixed write latency of 1 cycle; wr_en is 0 in cycles without a beat.
  - addr increments modulo 2^ADDR_W; wrap from all-ones to 0 is legal and silent.
  - On the beat where count==len-1: clear consumer's bit in mask. If the remaining mask is nonzero, go to SELECT; otherwise go to FINISH.
  - s_tready drops in the cycle after the last beat of each column, so there is 1 idle cycle between columns.
- FINISH:
  - done=1 for one cycle; busy stays 1 in this cycle.
  - Next cycle: IDLE, busy=0, consumer=0.
- Requests are captured only in IDLE. is_vstreamin, vec_len and base_addr changes during a job are ignored.
- A new request may be accepted in the cycle after FINISH.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, s_tready=0, no done pulse.
  - A write already registered for the abort cycle still completes.
  - abort in IDLE has no effect.
- Without an abort, s_tready never drops mid-column. Stalls come only from s_tvalid=0.
- The beat counter is LEN_W bits wide; len up to 2^LEN_W-1 is supported.

Optional Feature:
- Macro VSTREAMIN_TLAST_EN.
- Enabled:
  - Adds port s_tlast (in, 1) and output len_err (out, 1, sticky, cleared only by reset or the next job start).
  - len_err is set in either of two cases: s_tlast=1 on a beat other than the last beat of a column, or s_tlast=0 on the last beat of a column.
  - Sequencing still follows len; tlast never alters state transitions.
- Disabled: no s_tlast or len_err ports; tlast is not checked.

Test Plan:
- Basic job:
  - Stimulus: NUM_COL=8, is_vstreamin=8'b0000_0101, base_addr=4, vec_len=3, s_tvalid held 1, data 1..6.
  - Required: col0 gets addr 4,5,6 with data 1,2,3; col2 gets addr 4,5,6 with data 4,5,6; exactly 6 wr_en pulses; single done pulse; busy low the cycle after.
- Stall and wrap:
  - Stimulus: mask=8'h80, base_addr=30, vec_len=4, s_tvalid toggling 1,0,1,0,...
  - Required: writes to addr 30,31,0,1 only on beat cycles; consumer=8'h80 throughout.
- Zero length:
  - Stimulus: mask=8'hFF, vec_len=0.
  - Required: s_tready never 1, no wr_en, done pulses 2 cycles after request capture (SELECT, then FINISH).
- Abort mid-column:
  - Stimulus: mask=8'h03, vec_len=4, abort asserted after 2 beats.
  - Required: 2 writes to col0, no further s_tready, no done; a new request is then accepted normally.
- Async reset mid-STREAM:
  - Stimulus: rst_n pulled low between clock edges.
  - Required: all outputs 0 immediately; after release, IDLE and no spurious done.
- TLAST check (VSTREAMIN_TLAST_EN):
  - Stimulus: vec_len=3, s_tlast asserted on beat 2.
  - Required: len_err=1 and stays 1; beat 3 is still written.
